// File: rtl/gm_clk_pkg.sv
// gm_clk_pkg: shared state type, default parameters and counter sizing for the clock wrappers
package gm_clk_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, COUNT, RELEASE, RUN} state_t;
  localparam int SYNC_STAGES_D = 2;
  localparam int N_CH_D = 4;
  localparam int STABLE_CYCLES_D = 1024;
  localparam int STAGE_GAP_D = 16;
  localparam int LOSS_CNT_W_D = 8;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/gm_bit_sync.sv
// gm_bit_sync: multi-flop synchroniser for a single asynchronous bit, cleared to 0
module gm_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: debounces PLL lock, releases staged domain resets, supervises lock loss
module pll_reset_seq
  import gm_clk_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_D,
  parameter int N_CH          = N_CH_D,
  parameter int STABLE_CYCLES = STABLE_CYCLES_D,
  parameter int STAGE_GAP     = STAGE_GAP_D,
  parameter int LOSS_CNT_W    = LOSS_CNT_W_D
) (
  input  logic                  clock_in,
  input  logic                  rst_in,
  input  logic                  pll_lock,
  input  logic                  clr_lost,
  output logic [N_CH-1:0]       rst_n_out,
  output logic                  locked,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic                  pll_stdy_rst
);
  localparam int CW = cnt_width(STABLE_CYCLES, STAGE_GAP);
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lock_s;
  logic            lost_ev;
  logic [N_CH-1:0] nxt;
  gm_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clock_in),
    .rst_n(rst_in),
    .d    (pll_lock),
    .q    (lock_s)
  );
  assign lost_ev = !lock_s && (state == RELEASE || state == RUN);
  // thermometer step: one more channel released, bit 0 first
  assign nxt = N_CH'({rst_n_out, 1'b1});
  always_ff @(posedge clock_in or negedge rst_in)
    if (!rst_in) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      rst_n_out    <= '0;
      locked       <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      loss_cnt     <= '0;
      pll_stdy_rst <= 1'b0;
    end else begin
      pll_stdy_rst <= lost_ev;
      lock_lost    <= lost_ev | (lock_lost & ~clr_lost);
      if (lost_ev) begin
        state     <= WAIT_LOCK;
        cnt       <= '0;
        rst_n_out <= '0;
        locked    <= 1'b0;
        ready     <= 1'b0;
        if (~&loss_cnt) loss_cnt <= loss_cnt + 1'b1;
      end else
        case (state)
          WAIT_LOCK: begin
            cnt <= lock_s ? CW'(1) : '0;
            if (lock_s) state <= COUNT;
          end
          COUNT:
            if (!lock_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == CW'(STABLE_CYCLES)) begin
              state  <= RELEASE;
              locked <= 1'b1;
              cnt    <= '0;
            end else cnt <= cnt + 1'b1;
          RELEASE:
            if (rst_n_out == '0 || cnt == CW'(STAGE_GAP - 1)) begin
              rst_n_out <= nxt;
              cnt       <= '0;
              if (nxt[N_CH-1]) begin
                ready <= 1'b1;
                state <= RUN;
              end
            end else cnt <= cnt + 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed scenarios checked against a timeline model of the lock supervisor
module tb_pll_reset_seq;
  localparam int N = 3, STABLE = 8, GAP = 4, SYNC = 2;
  logic clock_in = 1'b0, rst_in = 1'b1, pll_lock = 1'b0, clr_lost = 1'b0;
  logic [N-1:0] rst_n_out;
  logic locked, ready, lock_lost, pll_stdy_rst;
  logic [7:0] loss_cnt;
  int checks = 0, failures = 0, n = 0, b = 0;
  bit live = 1'b0;
  bit m_up, m_lost, m_pulse, m_ready;
  int m_streak, m_ledge, m_cnt;
  logic [N-1:0] m_rst;
  bit sq[$];

  pll_reset_seq #(.SYNC_STAGES(SYNC), .N_CH(N), .STABLE_CYCLES(STABLE), .STAGE_GAP(GAP), .LOSS_CNT_W(8)) dut (
    .clock_in(clock_in), .rst_in(rst_in), .pll_lock(pll_lock), .clr_lost(clr_lost),
    .rst_n_out(rst_n_out), .locked(locked), .ready(ready), .lock_lost(lock_lost),
    .loss_cnt(loss_cnt), .pll_stdy_rst(pll_stdy_rst)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at step %0d: got=%0h expected=%0h", name, n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_up = 0; m_lost = 0; m_pulse = 0; m_ready = 0;
    m_streak = 0; m_ledge = 0; m_cnt = 0; m_rst = '0;
    sq.delete();
    repeat (SYNC) sq.push_back(1'b0);
  endtask

  // lock is declared after STABLE+1 consecutive synchronised-high samples; channels then follow a fixed timetable
  task automatic model_edge();
    bit ls;
    int rel;
    ls = sq.pop_front();
    sq.push_back(pll_lock);
    m_pulse = 0;
    if (m_up && !ls) begin
      m_up = 0; m_lost = 1; m_pulse = 1; m_streak = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (!m_up) begin
      m_streak = ls ? m_streak + 1 : 0;
      if (m_streak == STABLE + 1) begin
        m_up = 1; m_ledge = n; m_streak = 0;
      end
    end
    if (clr_lost && !m_pulse) m_lost = 0;
    rel = (m_up && n > m_ledge) ? (n - m_ledge - 1) / GAP + 1 : 0;
    if (rel > N) rel = N;
    m_rst = N'((1 << rel) - 1);
    m_ready = (rel == N);
  endtask

  task automatic step(input logic p, input logic c);
    pll_lock = p;
    clr_lost = c;
    @(posedge clock_in);
    n++;
    model_edge();
    #1;
  endtask

  task automatic goto(input int t, input logic p);
    while (n < t) step(p, 1'b0);
  endtask

  // packed view: {rst_n_out, locked, ready, lock_lost, pll_stdy_rst, loss_cnt}
  task automatic pin(input string name, input logic [14:0] e);
    chk({name, "_dut"}, int'({rst_n_out, locked, ready, lock_lost, pll_stdy_rst, loss_cnt}), int'(e));
    chk({name, "_model"}, int'({m_rst, m_up, m_ready, m_lost, m_pulse, 8'(m_cnt)}), int'(e));
  endtask

  always @(negedge clock_in)
    if (live) begin
      chk("rst_n_out", int'(rst_n_out), int'(m_rst));
      chk("locked", int'(locked), int'(m_up));
      chk("ready", int'(ready), int'(m_ready));
      chk("lock_lost", int'(lock_lost), int'(m_lost));
      chk("loss_cnt", int'(loss_cnt), m_cnt);
      chk("pll_stdy_rst", int'(pll_stdy_rst), int'(m_pulse));
    end

  initial begin
    model_reset();
    #1 rst_in = 1'b0;
    #1 pin("reset", 15'd0);
    #20 rst_in = 1'b1;
    live = 1'b1;
    // glitch: high, one low sample at step 6, high again
    goto(5, 1'b1);
    step(1'b0, 1'b0);
    goto(16, 1'b1);
    pin("glitch_e16", {3'b000, 4'b0000, 8'd0});
    goto(17, 1'b1);
    pin("glitch_e17", {3'b000, 4'b1000, 8'd0});
    goto(18, 1'b1);
    pin("glitch_e18", {3'b001, 4'b1000, 8'd0});
    goto(22, 1'b1);
    pin("glitch_e22", {3'b011, 4'b1000, 8'd0});
    // asynchronous reset between edges while two channels are out of reset
    #2 rst_in = 1'b0;
    model_reset();
    #1 pin("async_rst", 15'd0);
    rst_in = 1'b1;
    b = n;
    goto(b + 10, 1'b1);
    pin("clean_e10", {3'b000, 4'b0000, 8'd0});
    goto(b + 11, 1'b1);
    pin("clean_e11", {3'b000, 4'b1000, 8'd0});
    goto(b + 12, 1'b1);
    pin("clean_e12", {3'b001, 4'b1000, 8'd0});
    goto(b + 15, 1'b1);
    pin("clean_e15", {3'b001, 4'b1000, 8'd0});
    goto(b + 16, 1'b1);
    pin("clean_e16", {3'b011, 4'b1000, 8'd0});
    goto(b + 19, 1'b1);
    pin("clean_e19", {3'b011, 4'b1000, 8'd0});
    goto(b + 20, 1'b1);
    pin("clean_e20", {3'b111, 4'b1100, 8'd0});
    goto(b + 30, 1'b1);
    // loss in RUN
    b = n;
    goto(b + 2, 1'b0);
    pin("run_loss_e2", {3'b111, 4'b1100, 8'd0});
    goto(b + 3, 1'b0);
    pin("run_loss_e3", {3'b000, 4'b0011, 8'd1});
    b = n;
    goto(b + 1, 1'b1);
    pin("relock_e1", {3'b000, 4'b0010, 8'd1});
    goto(b + 11, 1'b1);
    pin("relock_e11", {3'b000, 4'b1010, 8'd1});
    goto(b + 20, 1'b1);
    pin("relock_e20", {3'b111, 4'b1110, 8'd1});
    goto(b + 25, 1'b1);
    step(1'b1, 1'b1);
    pin("clear", {3'b111, 4'b1100, 8'd1});
    // loss mid-release, with a clear landing on the loss edge
    b = n;
    goto(b + 3, 1'b0);
    pin("drop2", {3'b000, 4'b0011, 8'd2});
    b = n;
    goto(b + 4, 1'b1);
    step(1'b1, 1'b1);
    goto(b + 16, 1'b1);
    pin("mid_e16", {3'b011, 4'b1000, 8'd2});
    goto(b + 18, 1'b0);
    pin("mid_e18", {3'b011, 4'b1000, 8'd2});
    step(1'b0, 1'b1);
    pin("mid_loss", {3'b000, 4'b0011, 8'd3});
    goto(b + 23, 1'b0);
    pin("mid_after", {3'b000, 4'b0010, 8'd3});
    step(1'b0, 1'b1);
    pin("mid_clear", {3'b000, 4'b0000, 8'd3});
    // saturation: 257 more loss events, each caught right after lock
    for (int i = 0; i < 257; i++) begin
      repeat (11) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
    pin("saturate", {3'b000, 4'b0011, 8'd255});
    repeat (3) step(1'b0, 1'b0);
    live = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
Parametrised PLL-lock supervisor and staged reset generator, running in the PLL output clock domain (the clock_in of this block is the buffered PLL clock).
- Synchronises the raw PLL lock flag and debounces it over a programmable stable window.
- Releases N_CH active-low domain resets in timed stages.
- Detects lock loss, re-asserts all resets, reports a sticky flag plus a saturating loss counter, and pulses the PLL steady-lock reset.
- Supersedes the fixed two-flop lock synchroniser in the clock wrappers.

Parameters:
- SYNC_STAGES, 2, flops in the pll_lock synchroniser (≥2)
- N_CH, 4, number of staged reset outputs (≥1)
- STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (≥1)
- STAGE_GAP, 16, clock_in cycles between successive channel releases (≥1)
- LOSS_CNT_W, 8, width of the lock-loss event counter

Ports:
- clock_in  in  1  PLL output clock (the block's only clock)
- rst_in  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw PLL lock, asynchronous to clock_in
- clr_lost  in  1  single-cycle clear of lock_lost
- rst_n_out  out  N_CH  per-domain active-low resets; bit 0 released first
- locked  out  1  debounced lock
- ready  out  1  all channels released
- lock_lost  out  1  sticky lock-loss flag
- loss_cnt  out  LOSS_CNT_W  saturating count of lock-loss events
- pll_stdy_rst  out  1  one-cycle pulse to the PLL USR_LOCKED_STDY_RST

Behaviour:
- Reset values:
  - Asynchronous on rst_in=0; all outputs forced immediately.
  - rst_n_out=0, locked=0, ready=0, lock_lost=0, loss_cnt=0, pll_stdy_rst=0.
  - Synchroniser flops cleared; state=WAIT_LOCK.
- Synchroniser: lock_s is pll_lock delayed through SYNC_STAGES flops. No other logic samples pll_lock.
- All outputs are registered.
- Counter: cnt, width clog2(max(STABLE_CYCLES, STAGE_GAP))+1.
- WAIT_LOCK:
  - cnt=0.
  - lock_s=1 → COUNT with cnt=1.
- COUNT:
  - lock_s=0 → WAIT_LOCK, cnt=0; the debounce restarts from scratch.
  - lock_s=1 and cnt==STABLE_CYCLES → RELEASE, locked←1, cnt←0.
  - Otherwise cnt+1.
- Locked latency: with pll_lock constant high, locked rises exactly SYNC_STAGES+STABLE_CYCLES+1 rising edges after the first edge sampling pll_lock=1.
- RELEASE:
  - rst_n_out[0] rises 1 edge after locked.
  - rst_n_out[k] rises k*STAGE_GAP edges after rst_n_out[0].
  - Released bits stay 1; rst_n_out is thermometer-coded, with no bit k released before bit k-1.
  - On the edge that raises rst_n_out[N_CH-1], ready←1 and the state moves to RUN.
  - With N_CH=1, ready rises with rst_n_out[0].
- RUN: holds all outputs.
- Lock loss (lock_s=0 seen in RELEASE or RUN), on the next edge:
  - rst_n_out←0, locked←0, ready←0.
  - lock_lost←1.
  - loss_cnt+1, saturating at all-ones.
  - pll_stdy_rst←1 for exactly one cycle.
  - State → WAIT_LOCK.
  - Loss mid-RELEASE aborts the stage sequence; partially released channels are re-asserted together.
- lock_lost:
  - Cleared by clr_lost=1.
  - Set wins if set and clear happen in the same cycle.
  - clr_lost does not affect loss_cnt.
  - loss_cnt clears only on rst_in.
- Lock drop in WAIT_LOCK/COUNT is not a loss event: no flag, no counter increment, no pulse.
- rst_in deassertion is applied directly; any synchronisation of rst_in upstream is the integrator's responsibility.

Decomposition:
- Shared package gm_clk_pkg:
  - State typedef (WAIT_LOCK, COUNT, RELEASE, RUN), 2-bit encoding.
  - Default parameter constants.
  - clog2-based counter-width function.
- One sub-module: gm_bit_sync (parametrised SYNC_STAGES flop chain, async active-low clear, reset value 0), reusable by the other clock wrappers.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=8, STAGE_GAP=4, N_CH=3.
- Clean lock: pll_lock=1 from edge 0 → locked=1 at edge 11; rst_n_out = 001@12, 011@16, 111@20; ready=1@20; lock_lost=0, loss_cnt=0.
- Debounce glitch: pll_lock high edge 0, low for edge 5 only, high after → locked not before edge 17; no loss flag, loss_cnt=0.
- Loss in RUN: after ready, drop pll_lock at edge N → at edge N+3: rst_n_out=000, locked=0, ready=0, lock_lost=1, loss_cnt=1, pll_stdy_rst high for edge N+3 only; relock repeats the 11/12/16/20 timeline.
- Loss mid-RELEASE: drop pll_lock so lock_s falls after rst_n_out=011 → next edge rst_n_out=000, loss_cnt=1, rst_n_out[2] never rises.
- Sticky/clear/saturation: clr_lost pulsed on the loss edge → lock_lost stays 1; pulse later → 0, loss_cnt unchanged; 260 loss events → loss_cnt=255.
- Async reset mid-sequence: rst_in=0 while rst_n_out=011 → all outputs 0 before the next edge; after release, the timeline restarts from WAIT_LOCK.
